// File: rtl/multi_rate_divider.sv
// multi_rate_divider: NUM_CH independent tick generators, each pulsing every (period+1) enabled clocks.
module multi_rate_divider #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 28,
    parameter int CH_BITS = 2
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [CH_BITS-1:0] wr_ch,
    input  logic [WIDTH-1:0]   wr_value,
    input  logic               wr_mode,
    input  logic [NUM_CH-1:0]  enable,
    input  logic               sync,
    output logic [NUM_CH-1:0]  tick,
    output logic [NUM_CH-1:0]  armed,
    input  logic [CH_BITS-1:0] rd_ch,
    output logic [WIDTH-1:0]   rd_count
);
    logic [WIDTH-1:0]  period_q [NUM_CH];
    logic [WIDTH-1:0]  period_d [NUM_CH];
    logic [WIDTH-1:0]  count_q  [NUM_CH];
    logic [WIDTH-1:0]  count_d  [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] armed_q, armed_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    // write > sync > expiry > decrement > hold; one-shot disarms itself on expiry
    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        mode_d   = mode_q;
        armed_d  = armed_q;
        tick_d   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && wr_ch == CH_BITS'(c)) begin
                period_d[c] = wr_value;
                count_d[c]  = wr_value;
                mode_d[c]   = wr_mode;
                armed_d[c]  = 1'b1;
            end else if (armed_q[c] && sync) begin
                count_d[c] = period_q[c];
            end else if (armed_q[c] && enable[c]) begin
                if (count_q[c] == '0) begin
                    tick_d[c]  = 1'b1;
                    count_d[c] = mode_q[c] ? '0 : period_q[c];
                    armed_d[c] = ~mode_q[c];
                end else begin
                    count_d[c] = count_q[c] - WIDTH'(1);
                end
            end
        end
    end

    // unmatched select values fall through to 0
    always_comb begin
        rd_count = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (rd_ch == CH_BITS'(c)) rd_count = count_q[c];
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            period_q <= '{default: '0};
            count_q  <= '{default: '0};
            mode_q   <= '0;
            armed_q  <= '0;
            tick_q   <= '0;
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            armed_q  <= armed_d;
            tick_q   <= tick_d;
        end
    end

    assign tick  = tick_q;
    assign armed = armed_q;
endmodule

// File: tb/tb_multi_rate_divider.sv
// tb_multi_rate_divider: directed scoreboard bench for multi_rate_divider (4-channel and 3-channel instances).
module tb_multi_rate_divider;
    logic        clock, clear, wr_en, wr_en3, wr_mode, sync;
    logic [1:0]  wr_ch, rd_ch, rd_ch3;
    logic [27:0] wr_value, rd_count, rd_count3;
    logic [3:0]  enable, tick, armed;
    logic [2:0]  enable3, tick3, armed3;
    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [3:0]  tick;
        logic [3:0]  armed;
        logic [1:0]  ch;
        logic [27:0] cnt;
    } exp_t;
    exp_t sb[$];

    multi_rate_divider dut (
        .clock(clock), .clear(clear), .wr_en(wr_en), .wr_ch(wr_ch), .wr_value(wr_value),
        .wr_mode(wr_mode), .enable(enable), .sync(sync), .tick(tick), .armed(armed),
        .rd_ch(rd_ch), .rd_count(rd_count)
    );

    multi_rate_divider #(.NUM_CH(3), .WIDTH(28), .CH_BITS(2)) dut3 (
        .clock(clock), .clear(clear), .wr_en(wr_en3), .wr_ch(wr_ch), .wr_value(wr_value),
        .wr_mode(wr_mode), .enable(enable3), .sync(sync), .tick(tick3), .armed(armed3),
        .rd_ch(rd_ch3), .rd_count(rd_count3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] t, input logic [3:0] a,
                        input logic [1:0] ch, input logic [27:0] c);
        exp_t e;
        e.tag = tag; e.tick = t; e.armed = a; e.ch = ch; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_ch = e.ch;
            #1;
            chk({e.tag, ".tick"}, 32'(tick), 32'(e.tick));
            chk({e.tag, ".armed"}, 32'(armed), 32'(e.armed));
            chk({e.tag, ".count"}, 32'(rd_count), 32'(e.cnt));
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [27:0] v, input logic m);
        wr_en = 1'b1; wr_ch = ch; wr_value = v; wr_mode = m;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; wr_en3 = 1'b0; sync = 1'b0; enable = '0; enable3 = '0;
        clear = 1'b0;
        #1;
        clear = 1'b1;
    endtask

    initial begin
        clear = 1'b0; wr_en = 1'b0; wr_en3 = 1'b0; wr_mode = 1'b0; sync = 1'b0;
        wr_ch = '0; rd_ch = '0; rd_ch3 = '0; wr_value = '0; enable = '0; enable3 = '0;
        #2;
        chk("reset.tick", 32'(tick), 32'h0);
        chk("reset.armed", 32'(armed), 32'h0);
        chk("reset.count", 32'(rd_count), 32'h0);

        // periodic ch0, period 3
        do_reset();
        enable = 4'b0001;
        wr(2'd0, 28'd3, 1'b0);
        push("t1_wr", 4'b0000, 4'b0001, 2'd0, 28'd3);
        cyc();
        wr_en = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            push($sformatf("t1_k%0d", k), (k % 4 == 0) ? 4'b0001 : 4'b0000, 4'b0001, 2'd0, 28'(3 - (k % 4)));
            cyc();
        end

        // one-shot ch1, period 2; sync must not rearm it
        do_reset();
        enable = 4'b0010;
        wr(2'd1, 28'd2, 1'b1);
        push("t2_wr", 4'b0000, 4'b0010, 2'd1, 28'd2);
        cyc();
        wr_en = 1'b0;
        push("t2_c1", 4'b0000, 4'b0010, 2'd1, 28'd1);
        cyc();
        push("t2_c0", 4'b0000, 4'b0010, 2'd1, 28'd0);
        cyc();
        push("t2_tick", 4'b0010, 4'b0000, 2'd1, 28'd0);
        cyc();
        for (int k = 0; k < 20; k++) begin
            sync = (k == 5);
            push($sformatf("t2_idle%0d", k), 4'b0000, 4'b0000, 2'd1, 28'd0);
            cyc();
        end
        sync = 1'b0;

        // enable gap freezes the count
        do_reset();
        enable = 4'b0001;
        rd_ch = 2'd0;
        wr(2'd0, 28'd5, 1'b0);
        push("t3_wr", 4'b0000, 4'b0001, 2'd0, 28'd5);
        cyc();
        wr_en = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("t3_run%0d", k), 4'b0000, 4'b0001, 2'd0, 28'(5 - k));
            cyc();
        end
        enable = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            push($sformatf("t3_hold%0d", k), 4'b0000, 4'b0001, 2'd0, 28'd2);
            cyc();
        end
        enable = 4'b0001;
        push("t3_re1", 4'b0000, 4'b0001, 2'd0, 28'd1);
        cyc();
        push("t3_re0", 4'b0000, 4'b0001, 2'd0, 28'd0);
        cyc();
        push("t3_tick", 4'b0001, 4'b0001, 2'd0, 28'd5);
        cyc();

        // period 0 ticks every clock; clear acts without an edge
        do_reset();
        enable = 4'b0100;
        wr(2'd2, 28'd0, 1'b0);
        push("t4_wr", 4'b0000, 4'b0100, 2'd2, 28'd0);
        cyc();
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push($sformatf("t4_tick%0d", k), 4'b0100, 4'b0100, 2'd2, 28'd0);
            cyc();
        end
        #2;
        clear = 1'b0;
        #1;
        chk("t4_clr.tick", 32'(tick), 32'h0);
        chk("t4_clr.armed", 32'(armed), 32'h0);

        // sync realigns drifted channels
        do_reset();
        enable = 4'b1001;
        wr(2'd0, 28'd7, 1'b0);
        push("t5_w0", 4'b0000, 4'b0001, 2'd0, 28'd7);
        cyc();
        wr(2'd3, 28'd7, 1'b0);
        push("t5_w3", 4'b0000, 4'b1001, 2'd3, 28'd7);
        push("t5_w3_c0", 4'b0000, 4'b1001, 2'd0, 28'd6);
        cyc();
        wr_en = 1'b0;
        enable = 4'b0001;
        push("t5_d2", 4'b0000, 4'b1001, 2'd0, 28'd5);
        cyc();
        push("t5_d3", 4'b0000, 4'b1001, 2'd0, 28'd4);
        cyc();
        enable = 4'b1001;
        push("t5_d4_c0", 4'b0000, 4'b1001, 2'd0, 28'd3);
        push("t5_d4_c3", 4'b0000, 4'b1001, 2'd3, 28'd6);
        cyc();
        sync = 1'b1;
        push("t5_sync_c0", 4'b0000, 4'b1001, 2'd0, 28'd7);
        push("t5_sync_c3", 4'b0000, 4'b1001, 2'd3, 28'd7);
        cyc();
        sync = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            push($sformatf("t5_run%0d", k), 4'b0000, 4'b1001, 2'd0, 28'(7 - k));
            cyc();
        end
        push("t5_tick_c0", 4'b1001, 4'b1001, 2'd0, 28'd7);
        push("t5_tick_c3", 4'b1001, 4'b1001, 2'd3, 28'd7);
        cyc();
        push("t5_after_c3", 4'b0000, 4'b1001, 2'd3, 28'd6);
        cyc();

        // write beats expiry; neighbour keeps ticking
        do_reset();
        enable = 4'b0011;
        wr(2'd1, 28'd0, 1'b0);
        push("t6_w1", 4'b0000, 4'b0010, 2'd1, 28'd0);
        cyc();
        wr(2'd0, 28'd1, 1'b0);
        push("t6_w0", 4'b0010, 4'b0011, 2'd0, 28'd1);
        cyc();
        wr_en = 1'b0;
        push("t6_z", 4'b0010, 4'b0011, 2'd0, 28'd0);
        cyc();
        wr(2'd0, 28'd9, 1'b0);
        push("t6_wr_wins", 4'b0010, 4'b0011, 2'd0, 28'd9);
        cyc();
        wr_en = 1'b0;
        push("t6_dec", 4'b0010, 4'b0011, 2'd0, 28'd8);
        cyc();

        // out-of-range write on the 3-channel instance
        do_reset();
        wr_en3 = 1'b1; wr_ch = 2'd2; wr_value = 28'd4; wr_mode = 1'b0;
        cyc();
        rd_ch3 = 2'd2;
        #1;
        chk("t7_w2.armed", 32'(armed3), 32'h4);
        chk("t7_w2.count", 32'(rd_count3), 32'd4);
        wr_ch = 2'd3; wr_value = 28'd7;
        cyc();
        wr_en3 = 1'b0;
        #1;
        chk("t7_w3.armed", 32'(armed3), 32'h4);
        chk("t7_w3.tick", 32'(tick3), 32'h0);
        chk("t7_w3.count2", 32'(rd_count3), 32'd4);
        rd_ch3 = 2'd3;
        #1;
        chk("t7_w3.count3", 32'(rd_count3), 32'd0);
        chk("t7_main.armed", 32'(armed), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
